// File: rtl/or1200_vlx_pkg.sv
// Shared definitions for the VLX set-bit store sequencer.
package or1200_vlx_pkg;

  typedef enum logic [1:0] {
    VLX_IDLE  = 2'd0,
    VLX_STORE = 2'd1,
    VLX_STUFF = 2'd2,
    VLX_FLUSH = 2'd3
  } vlx_state_t;

  localparam logic [1:0] VLX_SPR_ADDR   = 2'd0;
  localparam logic [1:0] VLX_SPR_STATUS = 2'd1;
  localparam logic [1:0] VLX_SPR_CTRL   = 2'd2;
  localparam logic [1:0] VLX_SPR_BUF    = 2'd3;

  localparam int VLX_MAX_BITS = 16;

  // Byte value that triggers a 0x00 stuff byte in the marker-stuffing build.
  localparam logic [7:0] VLX_STUFF_BYTE = 8'hFF;

  // Limit a requested code length to the widest code the buffer accepts.
  function automatic logic [4:0] vlx_clamp(input logic [4:0] n, input logic [4:0] lim);
    return (n > lim) ? lim : n;
  endfunction

endpackage

// File: rtl/or1200_vlx_bitbuf.sv
// VLX bit buffer: code insertion, ones-padding and byte extraction.
// Bits are packed MSB-first; the oldest unstored bits sit at [cnt-1 -: 8].
module or1200_vlx_bitbuf #(
  parameter int BUF_W = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_ins,
  input  logic [4:0]       i_n,
  input  logic [31:0]      i_dat,
  input  logic             i_pad,
  input  logic             i_consume,
  output logic [BUF_W-1:0] o_buf,
  output logic [CNT_W-1:0] o_cnt,
  output logic [7:0]       o_byte
);

  logic [BUF_W-1:0] r_buf;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      w_mask;
  logic [3:0]       w_p;
  logic [BUF_W-1:0] w_pad_bits;
  logic [CNT_W-1:0] w_shift;

  // Mask off code bits above the requested length.
  assign w_mask     = (32'd1 << i_n) - 32'd1;
  // Pad amount brings cnt up to the next byte boundary (only used when cnt%8 != 0).
  assign w_p        = 4'd8 - {1'b0, r_cnt[2:0]};
  assign w_pad_bits = (BUF_W'(1) << w_p) - BUF_W'(1);
  assign w_shift    = r_cnt - CNT_W'(8);

  // Buffer and fill-level update; insert, pad and consume never coincide.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (i_ins) begin
      r_buf <= (r_buf << i_n) | BUF_W'(i_dat & w_mask);
      r_cnt <= r_cnt + CNT_W'(i_n);
    end else if (i_pad && (r_cnt[2:0] != 3'd0)) begin
      r_buf <= (r_buf << w_p) | w_pad_bits;
      r_cnt <= r_cnt + CNT_W'(w_p);
    end else if (i_consume) begin
      r_cnt <= r_cnt - CNT_W'(8);
    end
  end

  assign o_buf  = r_buf;
  assign o_cnt  = r_cnt;
  assign o_byte = 8'(r_buf >> w_shift);

endmodule

// File: rtl/or1200_vlx_ctrl.sv
// VLX set-bit store sequencer: packs SBIT codes and issues byte stores.
// Optional build macro OR1200_VLX_STUFF_EN enables JPEG 0xFF/0x00 stuffing.
module or1200_vlx_ctrl
  import or1200_vlx_pkg::*;
#(
  parameter int MAX_BITS = VLX_MAX_BITS,
  parameter int BUF_W    = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        set_bit_op_i,
  input  logic [4:0]  num_bits_to_write_i,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  output logic        stall_cpu_o,
  output logic [31:0] vlx_addr_o,
  output logic [31:0] dat_o,
  output logic        store_byte_o,
  input  logic        spr_cs,
  input  logic        spr_write,
  input  logic [1:0]  spr_addr,
  input  logic [31:0] spr_dat_i,
  output logic [31:0] spr_dat_o
);

  localparam int CNT_W = $clog2(BUF_W + 1);

  vlx_state_t       r_state;
  logic [31:0]      r_addr;
  logic             r_stall;
  logic             r_req;

  logic [BUF_W-1:0] w_buf;
  logic [CNT_W-1:0] w_cnt;
  logic [7:0]       w_byte;
  logic [4:0]       w_n;
  logic             w_spr_wr;
  logic             w_flush_req;
  logic             w_ins;
  logic             w_pad;
  logic             w_consume;
  logic [CNT_W-1:0] w_cnt_after_ins;
  logic [CNT_W-1:0] w_cnt_after_byte;

  assign w_n              = vlx_clamp(num_bits_to_write_i, 5'(MAX_BITS));
  assign w_spr_wr         = spr_cs & spr_write;
  assign w_flush_req      = w_spr_wr && (spr_addr == VLX_SPR_CTRL) && (r_state == VLX_IDLE);
  assign w_ins            = set_bit_op_i && (r_state == VLX_IDLE) && (w_n != 5'd0);
  assign w_pad            = (r_state == VLX_FLUSH);
  assign w_consume        = (r_state == VLX_STORE) && ack_i;
  assign w_cnt_after_ins  = w_cnt + CNT_W'(w_n);
  assign w_cnt_after_byte = w_cnt - CNT_W'(8);

  or1200_vlx_bitbuf #(
    .BUF_W (BUF_W),
    .CNT_W (CNT_W)
  ) u_bitbuf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_ins     (w_ins),
    .i_n       (w_n),
    .i_dat     (dat_i),
    .i_pad     (w_pad),
    .i_consume (w_consume),
    .o_buf     (w_buf),
    .o_cnt     (w_cnt),
    .o_byte    (w_byte)
  );

  // Sequencer FSM with registered stall/request and the store address.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= VLX_IDLE;
      r_stall <= 1'b0;
      r_req   <= 1'b0;
      r_addr  <= 32'h0;
    end else begin
      case (r_state)
        VLX_IDLE: begin
          if (w_spr_wr && (spr_addr == VLX_SPR_ADDR)) r_addr <= spr_dat_i;
          if (w_flush_req) begin
            r_state <= VLX_FLUSH;
            r_stall <= 1'b1;
          end else if (w_ins && (w_cnt_after_ins >= CNT_W'(8))) begin
            r_state <= VLX_STORE;
            r_stall <= 1'b1;
            r_req   <= 1'b1;
          end
        end
        VLX_FLUSH: begin
          // Padding happens this cycle; an empty buffer has nothing to store.
          if (w_cnt == '0) begin
            r_state <= VLX_IDLE;
            r_stall <= 1'b0;
          end else begin
            r_state <= VLX_STORE;
            r_req   <= 1'b1;
          end
        end
        VLX_STORE: begin
          if (ack_i) begin
            r_addr <= r_addr + 32'd1;
`ifdef OR1200_VLX_STUFF_EN
            if (w_byte == VLX_STUFF_BYTE) r_state <= VLX_STUFF;
            else
`endif
            if (w_cnt_after_byte < CNT_W'(8)) begin
              r_state <= VLX_IDLE;
              r_stall <= 1'b0;
              r_req   <= 1'b0;
            end
          end
        end
        VLX_STUFF: begin
          if (ack_i) begin
            r_addr <= r_addr + 32'd1;
            if (w_cnt >= CNT_W'(8)) begin
              r_state <= VLX_STORE;
            end else begin
              r_state <= VLX_IDLE;
              r_stall <= 1'b0;
              r_req   <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= VLX_IDLE;
          r_stall <= 1'b0;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign stall_cpu_o  = r_stall;
  assign store_byte_o = r_req;
  assign vlx_addr_o   = r_addr;
  // STUFF emits 0x00, so only STORE drives the extracted byte.
  assign dat_o        = (r_state == VLX_STORE) ? {24'h0, w_byte} : 32'h0;

  // SPR read mux.
  always_comb begin
    spr_dat_o = 32'h0;
    if (spr_cs) begin
      case (spr_addr)
        VLX_SPR_ADDR:   spr_dat_o = r_addr;
        VLX_SPR_STATUS: spr_dat_o = {22'h0, r_state, 3'h0, w_cnt[4:0]};
        VLX_SPR_CTRL:   spr_dat_o = 32'h0;
        VLX_SPR_BUF:    spr_dat_o = 32'(w_buf);
        default:        spr_dat_o = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_or1200_vlx_ctrl.sv
// Directed bench for or1200_vlx_ctrl (honours OR1200_VLX_STUFF_EN if defined).
module tb_or1200_vlx_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        set_bit_op_i = 1'b0;
  logic [4:0]  num_bits_to_write_i = 5'd0;
  logic [31:0] dat_i = 32'h0;
  logic        ack_i = 1'b0;
  logic        stall_cpu_o;
  logic [31:0] vlx_addr_o;
  logic [31:0] dat_o;
  logic        store_byte_o;
  logic        spr_cs = 1'b0;
  logic        spr_write = 1'b0;
  logic [1:0]  spr_addr = 2'd0;
  logic [31:0] spr_dat_i = 32'h0;
  logic [31:0] spr_dat_o;

  int vecs = 0;
  int errs = 0;
  logic [31:0] rd;

  or1200_vlx_ctrl dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .set_bit_op_i        (set_bit_op_i),
    .num_bits_to_write_i (num_bits_to_write_i),
    .dat_i               (dat_i),
    .ack_i               (ack_i),
    .stall_cpu_o         (stall_cpu_o),
    .vlx_addr_o          (vlx_addr_o),
    .dat_o               (dat_o),
    .store_byte_o        (store_byte_o),
    .spr_cs              (spr_cs),
    .spr_write           (spr_write),
    .spr_addr            (spr_addr),
    .spr_dat_i           (spr_dat_i),
    .spr_dat_o           (spr_dat_o)
  );

  always #5 clk_i = ~clk_i;

  // SBIT ops must never arrive while the CPU is stalled.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(set_bit_op_i && stall_cpu_o))
      else begin
        errs++;
        $error("FAIL sbit_while_stalled obs=1 exp=0");
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic spr_wr(input logic [1:0] a, input logic [31:0] d);
    spr_cs = 1'b1; spr_write = 1'b1; spr_addr = a; spr_dat_i = d;
    step();
    spr_cs = 1'b0; spr_write = 1'b0; spr_dat_i = 32'h0;
  endtask

  task automatic spr_rd(input logic [1:0] a, output logic [31:0] d);
    spr_cs = 1'b1; spr_write = 1'b0; spr_addr = a;
    #1;
    d = spr_dat_o;
    spr_cs = 1'b0;
  endtask

  task automatic sbit(input logic [4:0] n, input logic [31:0] d);
    set_bit_op_i = 1'b1; num_bits_to_write_i = n; dat_i = d;
    step();
    set_bit_op_i = 1'b0; num_bits_to_write_i = 5'd0; dat_i = 32'h0;
  endtask

  // Check a pending store, hold it for dly cycles, then ack it for one cycle.
  task automatic do_ack(input string tag, input logic [31:0] a, input logic [7:0] b, input int dly);
    check({tag, "_req"},  {31'h0, store_byte_o}, 32'h1);
    check({tag, "_addr"}, vlx_addr_o, a);
    check({tag, "_dat"},  dat_o, {24'h0, b});
    for (int i = 0; i < dly; i++) begin
      step();
      check({tag, "_hold_req"},  {31'h0, store_byte_o}, 32'h1);
      check({tag, "_hold_addr"}, vlx_addr_o, a);
      check({tag, "_hold_dat"},  dat_o, {24'h0, b});
    end
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
  endtask

  initial begin
    // Reset
    step();
    step();
    check("rst_store", {31'h0, store_byte_o}, 32'h0);
    check("rst_stall", {31'h0, stall_cpu_o}, 32'h0);
    check("rst_dat",   dat_o, 32'h0);
    check("rst_addr",  vlx_addr_o, 32'h0);
    rst_i = 1'b0;
    step();
    spr_rd(2'd1, rd); check("rst_status", rd, 32'h0);

    // 1: 3b'101 + 5b'10011 -> 0xB3 @0x1000
    spr_wr(2'd0, 32'h1000);
    sbit(5'd3, 32'h5);
    check("t1_nostall", {31'h0, stall_cpu_o}, 32'h0);
    check("t1_noreq",   {31'h0, store_byte_o}, 32'h0);
    spr_rd(2'd1, rd); check("t1_status3", rd, 32'h3);
    spr_rd(2'd3, rd); check("t1_buf", rd, 32'h5);
    sbit(5'd5, 32'h13);
    check("t1_stall", {31'h0, stall_cpu_o}, 32'h1);
    do_ack("t1_b0", 32'h1000, 8'hB3, 0);
    check("t1_idle_req",   {31'h0, store_byte_o}, 32'h0);
    check("t1_idle_stall", {31'h0, stall_cpu_o}, 32'h0);
    spr_rd(2'd0, rd); check("t1_addr", rd, 32'h1001);
    spr_rd(2'd1, rd); check("t1_status", rd, 32'h0);

    // 2: 16 bits 0xABCD (upper dat bits ignored)
    sbit(5'd16, 32'hFFFF_ABCD);
    do_ack("t2_b0", 32'h1001, 8'hAB, 0);
    check("t2_stall_mid", {31'h0, stall_cpu_o}, 32'h1);
    do_ack("t2_b1", 32'h1002, 8'hCD, 0);
    check("t2_stall_end", {31'h0, stall_cpu_o}, 32'h0);
    check("t2_req_end",   {31'h0, store_byte_o}, 32'h0);

    // 3: 3b'010 then flush -> 0x5F; flush when empty -> no store
    sbit(5'd3, 32'h2);
    spr_wr(2'd2, 32'h1234);
    check("t3_flush_stall", {31'h0, stall_cpu_o}, 32'h1);
    check("t3_flush_noreq", {31'h0, store_byte_o}, 32'h0);
    step();
    do_ack("t3_b0", 32'h1003, 8'h5F, 0);
    spr_rd(2'd1, rd); check("t3_status", rd, 32'h0);
    spr_rd(2'd2, rd); check("t3_ctrl_rd", rd, 32'h0);
    spr_wr(2'd2, 32'h1);
    check("t3_empty_req0", {31'h0, store_byte_o}, 32'h0);
    step();
    check("t3_empty_req1", {31'h0, store_byte_o}, 32'h0);
    check("t3_empty_stall", {31'h0, stall_cpu_o}, 32'h0);
    spr_rd(2'd0, rd); check("t3_addr", rd, 32'h1004);

    // 4: delayed ack, stable outputs, back-to-back request
    spr_wr(2'd0, 32'h2000);
    sbit(5'd16, 32'h1234);
    spr_rd(2'd1, rd); check("t4_status", rd, 32'h110);
    do_ack("t4_b0", 32'h2000, 8'h12, 5);
    do_ack("t4_b1", 32'h2001, 8'h34, 0);
    check("t4_end_req", {31'h0, store_byte_o}, 32'h0);

    // 5: 0xFF byte, stuffed with 0x00 only in the stuffing build
    spr_wr(2'd0, 32'h3000);
    sbit(5'd8, 32'hFF);
    do_ack("t5_ff", 32'h3000, 8'hFF, 0);
`ifdef OR1200_VLX_STUFF_EN
    do_ack("t5_stuff", 32'h3001, 8'h00, 0);
    check("t5_end_req", {31'h0, store_byte_o}, 32'h0);
    spr_rd(2'd0, rd); check("t5_addr", rd, 32'h3002);
`else
    check("t5_end_req", {31'h0, store_byte_o}, 32'h0);
    spr_rd(2'd0, rd); check("t5_addr", rd, 32'h3001);
`endif

    // 6: length 20 clamps to 16; reset mid-STORE aborts
    spr_wr(2'd0, 32'h4000);
    sbit(5'd20, 32'h000F_5A3C);
    do_ack("t6_b0", 32'h4000, 8'h5A, 0);
    spr_rd(2'd1, rd); check("t6_status", rd, 32'h108);
    check("t6_pending_dat", dat_o, 32'h3C);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("t6_rst_req",   {31'h0, store_byte_o}, 32'h0);
    check("t6_rst_stall", {31'h0, stall_cpu_o}, 32'h0);
    check("t6_rst_dat",   dat_o, 32'h0);
    check("t6_rst_addr",  vlx_addr_o, 32'h0);
    spr_rd(2'd0, rd); check("t6_spr_addr", rd, 32'h0);
    spr_rd(2'd1, rd); check("t6_spr_status", rd, 32'h0);
    spr_rd(2'd3, rd); check("t6_spr_buf", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
